string_feeder: RTL

- Upstream stage of the WS2812B string driver.
- On each frame_start, pops exactly NUM_PIXELS pixels from the pixel FIFO and reorders the colour bytes. Presents each pixel to the driver with a valid/ready handshake.
- After the last pixel it issues the blanking/reset request and holds it until the driver accepts it, then signals frame completion.
- Sits between the frame-buffer pixel FIFO and the string driver; one instance per LED string.

---
 rtl/string_feeder.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/string_feeder.sv
// -----------------------------------------------------------------------------
// string_feeder
//
// Upstream stage of a WS2812B string driver. On each frame_start it pops
// exactly NUM_PIXELS pixels from the frame-buffer FIFO. Each pixel has its
// colour bytes reordered and is handed to the driver over a valid/ready
// handshake. After the last pixel it requests blanking (h_blank), holds the
// request until the driver has entered blanking, waits for blanking to finish,
// and then pulses frame_done. There is one instance per LED string.
//
// Parameters
//   NUM_PIXELS   LEDs per string, 1..4095
//   COLOR_ORDER  0: FIFO {R,G,B} -> driver {G,R,B}; 1: pass-through
//
// Ports
//   clk               system clock, rising edge
//   rst               asynchronous active-high reset
//   frame_start       one-cycle request to send one frame
//   fifo_rd_data      FIFO data {R,G,B}, valid the cycle after fifo_rd_en
//   fifo_empty        FIFO empty flag
//   fifo_rd_en        FIFO pop strobe (combinational from state)
//   pixel_data        reordered pixel to the driver
//   pixel_data_valid  pixel_data valid
//   h_blank           blank/reset request to the driver
//   string_ready      driver ready; low while shifting or blanking
//   busy              frame in progress
//   frame_done        one-cycle pulse after blanking completes
//   underrun          sticky: FIFO empty seen mid-frame
//   overrun           sticky: frame_start seen while not accepting one
//
// State table
//   IDLE       | waiting for frame_start
//   FETCH      | popping next pixel; stalls while the FIFO is empty
//   CAPTURE    | FIFO data valid; register the reordered pixel
//   PRESENT    | pixel offered to the driver until string_ready
//   BLANK_WAIT | last pixel handed off; wait for the driver to finish it
//   BLANK_HOLD | h_blank asserted until the driver drops string_ready
//   BLANK_DONE | driver blanking; wait for ready, then pulse frame_done
// -----------------------------------------------------------------------------
module string_feeder #(
  parameter int NUM_PIXELS  = 150,
  parameter int COLOR_ORDER = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [23:0] fifo_rd_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [23:0] pixel_data,
  output logic        pixel_data_valid,
  output logic        h_blank,
  input  logic        string_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun,
  output logic        overrun
);

  // A single-pixel string still needs a one-bit counter to keep widths legal.
  localparam int              CNT_W    = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    PRESENT,
    BLANK_WAIT,
    BLANK_HOLD,
    BLANK_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [23:0]      pixel_next;
  logic             valid_next;
  logic             h_blank_next;
  logic             busy_next;
  logic             done_next;
  logic             underrun_next;
  logic             overrun_next;
  logic [23:0]      reordered;

  // Byte steering only; no arithmetic on colour data.
  generate
    if (COLOR_ORDER == 0) begin : g_grb
      assign reordered = {fifo_rd_data[15:8], fifo_rd_data[23:16], fifo_rd_data[7:0]};
    end else begin : g_pass
      assign reordered = fifo_rd_data;
    end
  endgenerate

  assign fifo_rd_en = (state == FETCH) && !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    count_next    = count;
    pixel_next    = pixel_data;
    valid_next    = pixel_data_valid;
    h_blank_next  = h_blank;
    busy_next     = busy;
    done_next     = 1'b0;
    underrun_next = underrun;
    overrun_next  = overrun;

    // A start request is only honoured in IDLE and not in the cycle that
    // frame_done pulses; every other start request is flagged and dropped.
    if (frame_start && ((state != IDLE) || frame_done)) begin
      overrun_next = 1'b1;
    end

    case (state)
      IDLE: begin
        if (frame_start && !frame_done) begin
          count_next    = '0;
          underrun_next = 1'b0;
          overrun_next  = 1'b0;
          busy_next     = 1'b1;
          state_next    = FETCH;
        end
      end

      FETCH: begin
        if (!fifo_empty) begin
          state_next = CAPTURE;
        end else if (count != '0) begin
          // Empty before the first pixel is normal; after it, the frame is late.
          underrun_next = 1'b1;
        end
      end

      CAPTURE: begin
        pixel_next = reordered;
        valid_next = 1'b1;
        state_next = PRESENT;
      end

      PRESENT: begin
        if (string_ready) begin
          valid_next = 1'b0;
          if (count == LAST_IDX) begin
            state_next = BLANK_WAIT;
          end else begin
            count_next = count + CNT_ONE;
            state_next = FETCH;
          end
        end
      end

      BLANK_WAIT: begin
        if (string_ready) begin
          h_blank_next = 1'b1;
          state_next   = BLANK_HOLD;
        end
      end

      BLANK_HOLD: begin
        // The driver only samples h_blank while idle, so keep it up until
        // the driver shows it has started blanking.
        if (!string_ready) begin
          h_blank_next = 1'b0;
          state_next   = BLANK_DONE;
        end
      end

      BLANK_DONE: begin
        if (string_ready) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count            <= '0;
      pixel_data       <= '0;
      pixel_data_valid <= 1'b0;
      h_blank          <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      underrun         <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      count            <= count_next;
      pixel_data       <= pixel_next;
      pixel_data_valid <= valid_next;
      h_blank          <= h_blank_next;
      busy             <= busy_next;
      frame_done       <= done_next;
      underrun         <= underrun_next;
      overrun          <= overrun_next;
    end
  end

endmodule
